// File: rtl/uart_pkg.sv
// Shared definitions for the counter UART transmitter: FSM encodings, frame width
// and an elaboration-time clog2 helper.
package uart_pkg;
   localparam int UART_DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word fall-through read port.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty
);
   localparam int AW = clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wptr, rptr;
   logic [AW:0]       count;
   logic              do_push, do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == (AW+1)'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; pointers alone define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end
endmodule

// File: rtl/counter_uart_tx.sv
// Buffers counter bytes in a FIFO and serialises them as back-to-back UART 8N1 frames.
module counter_uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx,
   output logic              busy,
   output logic              overflow
);
   localparam int BW = (clog2(CLKS_PER_BIT) < 1) ? 1 : clog2(CLKS_PER_BIT);

   uart_state_t       state, state_n;
   logic [BW-1:0]     baud, baud_n;
   logic [2:0]        bit_idx, bit_n;
   logic [DATA_W-1:0] shift_reg, shift_n, head;
   logic              tx_n, pop, push, full, empty, baud_done;

   assign in_ready  = !full;
   assign push      = in_valid && in_ready;
   assign busy      = (state != IDLE) || !empty;
   assign baud_done = (baud == BW'(CLKS_PER_BIT - 1));

   sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (in_data),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      state_n = state;
      baud_n  = baud_done ? '0 : baud + 1'b1;
      bit_n   = bit_idx;
      shift_n = shift_reg;
      tx_n    = tx;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            baud_n = '0;
            tx_n   = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               shift_n = head;
               tx_n    = 1'b0;
               state_n = START;
            end
         end
         START: if (baud_done) begin
            state_n = DATA;
            bit_n   = '0;
            tx_n    = shift_reg[0];
         end
         DATA: if (baud_done) begin
            if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
               state_n = STOP;
               tx_n    = 1'b1;
            end else begin
               bit_n = bit_idx + 3'd1;
               tx_n  = shift_reg[bit_idx + 3'd1];
            end
         end
         STOP: if (baud_done) begin
            // Chain straight into the next start bit when more data is waiting.
            if (!empty) begin
               pop     = 1'b1;
               shift_n = head;
               tx_n    = 1'b0;
               state_n = START;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         baud      <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         tx        <= 1'b1;
         overflow  <= 1'b0;
      end else begin
         state     <= state_n;
         baud      <= baud_n;
         bit_idx   <= bit_n;
         shift_reg <= shift_n;
         tx        <= tx_n;
         if (in_valid && !in_ready) overflow <= 1'b1;
      end
   end
endmodule
